// File: rtl/lap_timer_pkg.sv
// Shared encodings and BCD helpers for the lap timer and its digit cells.
package lap_timer_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUN     = 2'd1,
        ST_LAP     = 2'd2
    } state_t;

    localparam int             DIGIT_W   = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    // Preset nibbles above 9 are not valid BCD; clamp them to 9.
    function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] d);
        return (d > DIGIT_MAX) ? DIGIT_MAX : d;
    endfunction

endpackage

// File: rtl/lap_timer_bcd_digit.sv
// One BCD digit with up/down wrap, preset and clear; co_o is the carry (up) or borrow (down).
module bcd_digit
    import lap_timer_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               dir_i,
    input  logic               load_i,
    input  logic [DIGIT_W-1:0] load_val_i,
    input  logic               clear_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               co_o
);

    logic [DIGIT_W-1:0] r_digit;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_digit <= '0;
        end else if (load_i) begin
            r_digit <= load_val_i;
        end else if (en_i) begin
            if (dir_i) begin
                r_digit <= (r_digit == '0) ? DIGIT_MAX : r_digit - 4'd1;
            end else begin
                r_digit <= (r_digit == DIGIT_MAX) ? '0 : r_digit + 4'd1;
            end
        end
    end

    // Gated by en_i so the next digit only moves when this one actually wraps.
    assign co_o    = en_i && (dir_i ? (r_digit == '0) : (r_digit == DIGIT_MAX));
    assign digit_o = r_digit;

endmodule

// File: rtl/lap_timer.sv
// Up/down BCD lap timer: prescaler, run/lap FSM, lap capture and display select.
module lap_timer
    import lap_timer_pkg::*;
#(
    parameter logic [19:0] PULSE_MAX = 20'd499999,
    parameter int          DIGITS    = 4
)
(
    input  logic                   clk100_i,
    input  logic                   rst_i,
    input  logic                   start_stop_i,
    input  logic                   lap_i,
    input  logic                   clear_i,
    input  logic                   load_i,
    input  logic [4*DIGITS-1:0]    load_value_i,
    input  logic                   mode_down_i,
    output logic [4*DIGITS-1:0]    bcd_o,
    output logic                   running_o,
    output logic                   lap_o,
    output logic                   expired_o,
    output logic                   overflow_o
);

    localparam int CW = DIGIT_W * DIGITS;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [19:0]       r_presc;
    logic [CW-1:0]     r_lap_val;
    logic              r_running;
    logic              r_lap_on;
    logic              r_expired;
    logic              r_overflow;

    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_load_sat;
    logic [DIGITS-1:0] w_en;
    logic [DIGITS-1:0] w_co;
    logic              w_is_zero;
    logic              w_is_one;
    logic              w_tick;
    logic              w_tick_use;
    logic              w_cnt_en;
    logic              w_expire;
    logic              w_overflow;
    logic              w_load_act;
    logic              w_lap_cap;
    logic              w_running_nxt;
    logic              w_lap_nxt;

    assign w_is_zero  = (w_count == '0);
    assign w_is_one   = (w_count == CW'(1));
    assign w_tick     = (r_state != ST_STOPPED) && (r_presc == PULSE_MAX);
    // clear/load present on a tick cycle swallow that tick.
    assign w_tick_use = w_tick && !clear_i && !load_i;
    // A down tick at zero (mode flipped mid-run) must not wrap to all-9.
    assign w_cnt_en   = w_tick_use && !(mode_down_i && w_is_zero);
    assign w_expire   = w_tick_use && mode_down_i && (w_is_zero || w_is_one);
    assign w_overflow = w_co[DIGITS-1] && !mode_down_i;
    assign w_load_act = load_i && !clear_i && (r_state == ST_STOPPED);
    assign w_lap_cap  = lap_i && !clear_i && !load_i && !start_stop_i
                        && (r_state != ST_STOPPED);

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        if (k == 0) begin : g_lsd
            assign w_en[k] = w_cnt_en;
        end else begin : g_chain
            assign w_en[k] = w_cnt_en & w_co[k-1];
        end

        assign w_load_sat[k*DIGIT_W +: DIGIT_W] = sat_digit(load_value_i[k*DIGIT_W +: DIGIT_W]);

        bcd_digit u_digit (
            .clk_i      (clk100_i),
            .rst_i      (rst_i),
            .en_i       (w_en[k]),
            .dir_i      (mode_down_i),
            .load_i     (w_load_act),
            .load_val_i (w_load_sat[k*DIGIT_W +: DIGIT_W]),
            .clear_i    (clear_i),
            .digit_o    (w_count[k*DIGIT_W +: DIGIT_W]),
            .co_o       (w_co[k])
        );
    end

    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            r_state <= ST_STOPPED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear_i) begin
            w_state_nxt = ST_STOPPED;
        end else if (load_i) begin
            w_state_nxt = r_state;
        end else if (start_stop_i) begin
            if (r_state == ST_STOPPED) begin
                w_state_nxt = (mode_down_i && w_is_zero) ? ST_STOPPED : ST_RUN;
            end else begin
                w_state_nxt = ST_STOPPED;
            end
        end else if (lap_i && (r_state != ST_STOPPED)) begin
            w_state_nxt = ST_LAP;
        end
        if (w_expire) begin
            w_state_nxt = ST_STOPPED;
        end
    end

    always_comb begin
        w_running_nxt = (w_state_nxt != ST_STOPPED);
        w_lap_nxt     = (w_state_nxt == ST_LAP);
    end

    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            r_running  <= 1'b0;
            r_lap_on   <= 1'b0;
            r_expired  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_running  <= w_running_nxt;
            r_lap_on   <= w_lap_nxt;
            r_expired  <= w_expire;
            r_overflow <= w_overflow;
        end
    end

    // Prescaler holds while stopped so a resumed run keeps its sub-tick phase.
    always_ff @(posedge clk100_i) begin
        if (rst_i || clear_i) begin
            r_presc <= '0;
        end else if (w_expire) begin
            r_presc <= '0;
        end else if (r_state != ST_STOPPED) begin
            r_presc <= (r_presc == PULSE_MAX) ? 20'd0 : r_presc + 20'd1;
        end
    end

    always_ff @(posedge clk100_i) begin
        if (rst_i || clear_i) begin
            r_lap_val <= '0;
        end else if (w_lap_cap) begin
            r_lap_val <= w_count;
        end
    end

    assign bcd_o      = r_lap_on ? r_lap_val : w_count;
    assign running_o  = r_running;
    assign lap_o      = r_lap_on;
    assign expired_o  = r_expired;
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_lap_timer.sv
// Directed bench for lap_timer with a 4-cycle tick and four digits.
module tb_lap_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_stop;
    logic        lap;
    logic        clear;
    logic        load;
    logic [15:0] load_value;
    logic        mode_down;
    logic [15:0] bcd;
    logic        running;
    logic        lap_on;
    logic        expired;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    lap_timer #(.PULSE_MAX(20'd3), .DIGITS(4)) dut (
        .clk100_i     (clk),
        .rst_i        (rst),
        .start_stop_i (start_stop),
        .lap_i        (lap),
        .clear_i      (clear),
        .load_i       (load),
        .load_value_i (load_value),
        .mode_down_i  (mode_down),
        .bcd_o        (bcd),
        .running_o    (running),
        .lap_o        (lap_on),
        .expired_o    (expired),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1; step(1); start_stop = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1; step(1); lap = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(1); clear = 1'b0;
    endtask

    task automatic pulse_load(input logic [15:0] v);
        load_value = v; load = 1'b1; step(1); load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
        load = 1'b0; load_value = 16'h0; mode_down = 1'b0;
        step(2);
        rst = 1'b0;
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_running", 32'(running), 32'h0);
        check("rst_lap", 32'(lap_on), 32'h0);
        check("rst_expired", 32'(expired), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);

        // up count from zero
        pulse_ss();
        check("up_running", 32'(running), 32'h1);
        step(3);
        check("up_pre_tick", 32'(bcd), 32'h0000);
        step(1);
        check("up_first_tick", 32'(bcd), 32'h0001);
        step(36);
        check("up_40cyc", 32'(bcd), 32'h0010);
        check("up_running_40", 32'(running), 32'h1);
        pulse_ss();
        check("up_stopped", 32'(running), 32'h0);
        pulse_clear();
        check("clear_bcd", 32'(bcd), 32'h0000);

        // up wrap from all-9
        pulse_load(16'h9999);
        check("wrap_load", 32'(bcd), 32'h9999);
        pulse_ss();
        step(3);
        check("wrap_pre", 32'(bcd), 32'h9999);
        check("wrap_pre_ovf", 32'(overflow), 32'h0);
        step(1);
        check("wrap_bcd", 32'(bcd), 32'h0000);
        check("wrap_ovf", 32'(overflow), 32'h1);
        step(1);
        check("wrap_ovf_one_cycle", 32'(overflow), 32'h0);
        step(3);
        check("wrap_continue", 32'(bcd), 32'h0001);
        pulse_clear();
        check("wrap_clear_run", 32'(running), 32'h0);

        // countdown to expiry
        mode_down = 1'b1;
        pulse_load(16'h0003);
        pulse_ss();
        step(4);
        check("down_2", 32'(bcd), 32'h0002);
        step(4);
        check("down_1", 32'(bcd), 32'h0001);
        check("down_run", 32'(running), 32'h1);
        step(3);
        check("down_no_exp_yet", 32'(expired), 32'h0);
        step(1);
        check("down_0", 32'(bcd), 32'h0000);
        check("down_expired", 32'(expired), 32'h1);
        check("down_stopped", 32'(running), 32'h0);
        step(1);
        check("down_exp_one_cycle", 32'(expired), 32'h0);
        pulse_ss();
        check("down_start_ignored", 32'(running), 32'h0);
        mode_down = 1'b0;
        pulse_clear();

        // lap and split
        pulse_ss();
        step(20);
        check("lap_live5", 32'(bcd), 32'h0005);
        pulse_lap();
        check("lap_on", 32'(lap_on), 32'h1);
        check("lap_hold5", 32'(bcd), 32'h0005);
        step(15);
        check("lap_frozen", 32'(bcd), 32'h0005);
        check("lap_running", 32'(running), 32'h1);
        pulse_lap();
        check("split_9", 32'(bcd), 32'h0009);
        check("split_lap_on", 32'(lap_on), 32'h1);
        step(3);
        check("split_frozen", 32'(bcd), 32'h0009);
        pulse_ss();
        check("lap_stop_live", 32'(bcd), 32'h0010);
        check("lap_stop_lap_off", 32'(lap_on), 32'h0);
        check("lap_stop_running", 32'(running), 32'h0);

        // prescaler held at 1 while stopped: tick lands 3 edges after restart
        pulse_ss();
        step(1);
        check("hold_phase", 32'(bcd), 32'h0010);
        clear = 1'b1; start_stop = 1'b1;
        step(1);
        clear = 1'b0; start_stop = 1'b0;
        check("clr_tick_bcd", 32'(bcd), 32'h0000);
        check("clr_tick_running", 32'(running), 32'h0);
        check("clr_tick_lap", 32'(lap_on), 32'h0);

        // prescaler was zeroed by clear
        pulse_ss();
        step(3);
        check("clr_presc_pre", 32'(bcd), 32'h0000);
        step(1);
        check("clr_presc_tick", 32'(bcd), 32'h0001);
        pulse_load(16'h5555);
        check("load_in_run", 32'(bcd), 32'h0001);
        check("load_in_run_running", 32'(running), 32'h1);
        pulse_clear();

        pulse_load(16'hA0F3);
        check("load_saturate", 32'(bcd), 32'h9093);
        pulse_clear();

        // reset while in LAP
        pulse_ss();
        step(5);
        pulse_lap();
        check("pre_rst_lap", 32'(lap_on), 32'h1);
        rst = 1'b1; step(1); rst = 1'b0;
        check("midrst_bcd", 32'(bcd), 32'h0000);
        check("midrst_running", 32'(running), 32'h0);
        check("midrst_lap", 32'(lap_on), 32'h0);
        check("midrst_expired", 32'(expired), 32'h0);
        check("midrst_overflow", 32'(overflow), 32'h0);

        // down mode selected mid-interval while count is zero
        pulse_ss();
        mode_down = 1'b1;
        step(3);
        check("flip_running", 32'(running), 32'h1);
        step(1);
        check("flip_bcd", 32'(bcd), 32'h0000);
        check("flip_expired", 32'(expired), 32'h1);
        check("flip_stopped", 32'(running), 32'h0);
        mode_down = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
